// File: rtl/adpll_lock_ctrl.sv
// Acquisition/tracking lock sequencer for the ring-oscillator ADPLL.
// Define ADPLL_LOCK_CTRL_SAT_DET_EN to treat a saturated DCO code as out-of-window.
module adpll_lock_ctrl #(
  parameter int unsigned PDET_WIDTH = 5,
  parameter int unsigned RO_WIDTH   = 5,
  parameter int unsigned KP_WIDTH   = 6,
  parameter int unsigned KI_WIDTH   = 4,
  parameter logic [KP_WIDTH-1:0] KP_COARSE = 6'd18,
  parameter logic [KI_WIDTH-1:0] KI_COARSE = 4'd4,
  parameter logic [KP_WIDTH-1:0] KP_FINE   = 6'd9,
  parameter logic [KI_WIDTH-1:0] KI_FINE   = 4'd1,
  parameter int unsigned WARMUP_CYC    = 256,
  parameter int unsigned LOCK_THRESH   = 1,
  parameter int unsigned UNLOCK_THRESH = 3,
  parameter int unsigned LOCK_CNT      = 16,
  parameter int unsigned UNLOCK_CNT    = 4,
  parameter int unsigned ACQ_TIMEOUT   = 4096
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  ref_clk_i,
  input  logic [PDET_WIDTH-1:0] error_i,
  input  logic [RO_WIDTH-1:0]   dco_cc_i,
  output logic                  enable_o,
  output logic [KP_WIDTH-1:0]   kp_o,
  output logic [KI_WIDTH-1:0]   ki_o,
  output logic                  locked_o,
  output logic                  lock_lost_o,
  output logic                  fault_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WARMUP  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  localparam int unsigned WW = $clog2(WARMUP_CYC + 1);
  localparam int unsigned LW = $clog2(LOCK_CNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);
  localparam int unsigned AW = $clog2(ACQ_TIMEOUT + 1);
  localparam int unsigned EW = PDET_WIDTH + 1;

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_CNT);
  localparam logic [UW-1:0] UNL_MAX   = UW'(UNLOCK_CNT);
  localparam logic [AW-1:0] ACQ_MAX   = AW'(ACQ_TIMEOUT);
  localparam logic [EW-1:0] LOCK_TH   = EW'(LOCK_THRESH);
  localparam logic [EW-1:0] UNL_TH    = EW'(UNLOCK_THRESH);

  state_e          state_q, state_d;
  logic [WW-1:0]   warm_q, warm_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [UW-1:0]   unl_q, unl_d;
  logic [AW-1:0]   acq_q, acq_d;
  logic            lost_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic            ref_evt;

  logic [EW-1:0]   err_ext, err_abs;
  logic            in_win_raw, out_win_raw, in_win, out_win;
  logic [LW-1:0]   lock_nx;
  logic [AW-1:0]   acq_nx;
  logic [UW-1:0]   unl_nx;

  assign ref_evt = sync2_q & ~sync3_q;

  // Sign-extend by one bit so the most-negative error has a representable magnitude.
  assign err_ext     = {error_i[PDET_WIDTH-1], error_i};
  assign err_abs     = err_ext[EW-1] ? (-err_ext) : err_ext;
  assign in_win_raw  = (err_abs <= LOCK_TH);
  assign out_win_raw = (err_abs > UNL_TH);

`ifdef ADPLL_LOCK_CTRL_SAT_DET_EN
  logic dco_sat;
  assign dco_sat = (dco_cc_i == {1'b0, {(RO_WIDTH-1){1'b1}}}) ||
                   (dco_cc_i == {1'b1, {(RO_WIDTH-1){1'b0}}});
  assign in_win  = in_win_raw & ~dco_sat;
  assign out_win = out_win_raw | dco_sat;
`else
  logic unused_dco;
  assign unused_dco = ^dco_cc_i;
  assign in_win     = in_win_raw;
  assign out_win    = out_win_raw;
`endif

  assign lock_nx = !in_win ? '0 : ((lock_q == LOCK_MAX) ? lock_q : lock_q + LW'(1));
  assign acq_nx  = (acq_q == ACQ_MAX) ? acq_q : acq_q + AW'(1);
  assign unl_nx  = !out_win ? '0 : ((unl_q == UNL_MAX) ? unl_q : unl_q + UW'(1));

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    lock_d  = lock_q;
    unl_d   = unl_q;
    acq_d   = acq_q;
    lost_d  = 1'b0;
    if (!start_i) begin
      state_d = ST_IDLE;
      warm_d  = '0;
      lock_d  = '0;
      unl_d   = '0;
      acq_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_WARMUP;
          warm_d  = '0;
        end
        ST_WARMUP: begin
          if (warm_q == WARM_LAST) begin
            state_d = ST_ACQUIRE;
            warm_d  = '0;
            lock_d  = '0;
            unl_d   = '0;
            acq_d   = '0;
          end else begin
            warm_d = warm_q + WW'(1);
          end
        end
        ST_ACQUIRE: begin
          // Lock is tested before timeout so a coincident lock still succeeds.
          if (ref_evt) begin
            if (lock_nx == LOCK_MAX) begin
              state_d = ST_TRACK;
              lock_d  = '0;
              acq_d   = '0;
              unl_d   = '0;
            end else if (acq_nx == ACQ_MAX) begin
              state_d = ST_FAULT;
              lock_d  = '0;
              acq_d   = '0;
            end else begin
              lock_d = lock_nx;
              acq_d  = acq_nx;
            end
          end
        end
        ST_TRACK: begin
          if (ref_evt) begin
            if (unl_nx == UNL_MAX) begin
              state_d = ST_ACQUIRE;
              lost_d  = 1'b1;
              lock_d  = '0;
              acq_d   = '0;
              unl_d   = '0;
            end else begin
              unl_d = unl_nx;
            end
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      warm_q      <= '0;
      lock_q      <= '0;
      unl_q       <= '0;
      acq_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      enable_o    <= 1'b0;
      kp_o        <= KP_COARSE;
      ki_o        <= KI_COARSE;
      locked_o    <= 1'b0;
      lock_lost_o <= 1'b0;
      fault_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      lock_q      <= lock_d;
      unl_q       <= unl_d;
      acq_q       <= acq_d;
      sync1_q     <= ref_clk_i;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      enable_o    <= (state_d == ST_WARMUP) || (state_d == ST_ACQUIRE) ||
                     (state_d == ST_TRACK);
      kp_o        <= (state_d == ST_TRACK) ? KP_FINE : KP_COARSE;
      ki_o        <= (state_d == ST_TRACK) ? KI_FINE : KI_COARSE;
      locked_o    <= (state_d == ST_TRACK);
      lock_lost_o <= lost_d;
      fault_o     <= (state_d == ST_FAULT);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_adpll_lock_ctrl.sv
// Directed bench for adpll_lock_ctrl; honours ADPLL_LOCK_CTRL_SAT_DET_EN when defined.
module tb_adpll_lock_ctrl;

  logic       fpga_clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       ref_clk;
  logic [4:0] error;
  logic [4:0] dco;
  logic       enable_o, locked_o, lock_lost_o, fault_o;
  logic [5:0] kp_o;
  logic [3:0] ki_o;
  logic [2:0] state_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pulses = 0;
  int unsigned pulses_before;

  adpll_lock_ctrl dut (
    .fpga_clk_i (fpga_clk),
    .reset_n_i  (reset_n),
    .start_i    (start),
    .ref_clk_i  (ref_clk),
    .error_i    (error),
    .dco_cc_i   (dco),
    .enable_o   (enable_o),
    .kp_o       (kp_o),
    .ki_o       (ki_o),
    .locked_o   (locked_o),
    .lock_lost_o(lock_lost_o),
    .fault_o    (fault_o),
    .state_o    (state_o)
  );

  always #5 fpga_clk = ~fpga_clk;

  always @(posedge fpga_clk) begin
    #1;
    if (lock_lost_o) pulses++;
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge fpga_clk);
  endtask

  // Rising ref edge; returns once the FSM has consumed the resulting ref event.
  task automatic ref_rise();
    ref_clk = 1'b1;
    repeat (3) tick();
  endtask

  task automatic ref_fall();
    tick();
    ref_clk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic ref_edges(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ref_rise();
      ref_fall();
    end
  endtask

  initial begin
    reset_n = 1'b1;
    start   = 1'b0;
    ref_clk = 1'b0;
    error   = 5'd0;
    dco     = 5'd0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("rst_state", state_o, 0);
    check("rst_enable", enable_o, 0);
    check("rst_kp", kp_o, 18);
    check("rst_ki", ki_o, 4);
    check("rst_locked", locked_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_lost", lock_lost_o, 0);
    reset_n = 1'b1;
    tick();

    // Warmup then acquisition to lock with zero error.
    start = 1'b1;
    tick();
    check("warm_enter", state_o, 1);
    check("warm_enable", enable_o, 1);
    repeat (255) tick();
    check("warm_last", state_o, 1);
    tick();
    check("acq_enter", state_o, 2);
    check("acq_kp", kp_o, 18);
    ref_edges(15);
    check("acq_15", state_o, 2);
    ref_edges(1);
    check("trk_state", state_o, 3);
    check("trk_kp", kp_o, 9);
    check("trk_ki", ki_o, 1);
    check("trk_locked", locked_o, 1);
    check("trk_enable", enable_o, 1);

    // Three outliers, recovery, then four consecutive outliers.
    error = 5'd4;
    ref_edges(3);
    error = 5'd0;
    ref_edges(1);
    check("trk_hold", state_o, 3);
    error = 5'b11011;
    ref_edges(3);
    check("trk_3out", state_o, 3);
    check("trk_3lost", lock_lost_o, 0);
    ref_rise();
    check("loss_state", state_o, 2);
    check("loss_pulse", lock_lost_o, 1);
    check("loss_kp", kp_o, 18);
    check("loss_locked", locked_o, 0);
    tick();
    check("loss_pulse_end", lock_lost_o, 0);
    ref_clk = 1'b0;
    repeat (4) tick();
    check("loss_count", pulses, 1);

    // Lock count restarts after a single marginal sample.
    error = 5'd0;
    ref_edges(15);
    error = 5'd2;
    ref_edges(1);
    error = 5'd0;
    ref_edges(15);
    check("relock_31", state_o, 2);
    ref_edges(1);
    check("relock_32", state_o, 3);

    // Saturated DCO code while tracking.
    dco = 5'd15;
    ref_edges(4);
`ifdef ADPLL_LOCK_CTRL_SAT_DET_EN
    check("sat_state", state_o, 2);
    check("sat_count", pulses, 2);
`else
    check("sat_state", state_o, 3);
    check("sat_count", pulses, 1);
`endif
    dco = 5'd0;
    ref_edges(16);
    check("pre_rst_trk", state_o, 3);

    // Asynchronous reset mid-track.
    pulses_before = pulses;
    reset_n = 1'b0;
    #1;
    check("arst_state", state_o, 0);
    check("arst_locked", locked_o, 0);
    check("arst_enable", enable_o, 0);
    check("arst_kp", kp_o, 18);
    check("arst_ki", ki_o, 4);
    tick();
    tick();
    check("arst_nopulse", pulses, pulses_before);
    reset_n = 1'b1;

    // Most-negative error never locks; acquisition times out.
    error = 5'b10000;
    tick();
    check("flt_warm", state_o, 1);
    repeat (256) tick();
    check("flt_acq", state_o, 2);
    ref_edges(4095);
    check("flt_4095", state_o, 2);
    check("flt_4095_f", fault_o, 0);
    ref_edges(1);
    check("flt_state", state_o, 4);
    check("flt_fault", fault_o, 1);
    check("flt_enable", enable_o, 0);
    check("flt_kp", kp_o, 18);
    check("flt_locked", locked_o, 0);
    ref_edges(2);
    check("flt_park", state_o, 4);
    start = 1'b0;
    tick();
    check("flt_exit", state_o, 0);
    check("flt_clear", fault_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
